// File: rtl/jbi_jpack_pkg.sv
// Shared J_PACK definitions: channel indices, default flow-control thresholds,
// flow-control request encodings and the fixed-priority request picker.
package jbi_jpack_pkg;

  localparam int unsigned CH_AOK = 0;
  localparam int unsigned CH_DOK = 1;

  localparam logic [5:0] DEF_AOK_OFF_THR = 6'd40;
  localparam logic [5:0] DEF_AOK_ON_THR  = 6'd32;
  localparam logic [5:0] DEF_DOK_OFF_THR = 6'd40;
  localparam logic [5:0] DEF_DOK_ON_THR  = 6'd32;

  typedef enum logic [2:0] {
    JP_NONE    = 3'd0,
    JP_AOK_OFF = 3'd1,
    JP_DOK_OFF = 3'd2,
    JP_AOK_ON  = 3'd3,
    JP_DOK_ON  = 3'd4
  } jpack_fc_e;

  // OFF requests beat ON requests so the buffers are protected first.
  function automatic jpack_fc_e fc_pick(input logic [1:0] want_off, input logic [1:0] want_on);
    jpack_fc_e pick;
    if (want_off[CH_AOK])     pick = JP_AOK_OFF;
    else if (want_off[CH_DOK]) pick = JP_DOK_OFF;
    else if (want_on[CH_AOK])  pick = JP_AOK_ON;
    else if (want_on[CH_DOK])  pick = JP_DOK_ON;
    else                       pick = JP_NONE;
    return pick;
  endfunction

endpackage

// File: rtl/jbi_jpack_fc_ctl_if.sv
// Occupancy/CSR inputs and flow-control request outputs of the J_PACK FC scheduler.
interface jbi_jpack_fc_ctl_if #(
  parameter int CW     = 6,
  parameter int STAT_W = 16
);
  logic [CW-1:0]     aok_occ;
  logic [CW-1:0]     dok_occ;
  logic [CW-1:0]     csr_aok_off_thr;
  logic [CW-1:0]     csr_aok_on_thr;
  logic [CW-1:0]     csr_dok_off_thr;
  logic [CW-1:0]     csr_dok_on_thr;
  logic              csr_fc_dis;
  logic              dok_fatal_hold;
  logic              send_aok_off;
  logic              send_aok_on;
  logic              send_dok_off;
  logic              send_dok_on;
  logic              aok_is_on;
  logic              dok_is_on;
  logic [STAT_W-1:0] stat_aok_off_cnt;
  logic [STAT_W-1:0] stat_dok_off_cnt;

  modport master (
    output aok_occ, dok_occ, csr_aok_off_thr, csr_aok_on_thr,
           csr_dok_off_thr, csr_dok_on_thr, csr_fc_dis, dok_fatal_hold,
    input  send_aok_off, send_aok_on, send_dok_off, send_dok_on,
           aok_is_on, dok_is_on, stat_aok_off_cnt, stat_dok_off_cnt
  );

  modport slave (
    input  aok_occ, dok_occ, csr_aok_off_thr, csr_aok_on_thr,
           csr_dok_off_thr, csr_dok_on_thr, csr_fc_dis, dok_fatal_hold,
    output send_aok_off, send_aok_on, send_dok_off, send_dok_on,
           aok_is_on, dok_is_on, stat_aok_off_cnt, stat_dok_off_cnt
  );
endinterface

// File: rtl/jbi_jpack_fc_hyst.sv
// One flow-control channel: tracked bus on/off state plus threshold hysteresis compare.
module jbi_jpack_fc_hyst #(
  parameter int CW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] i_occ,
  input  logic [CW-1:0] i_off_thr,
  input  logic [CW-1:0] i_on_thr,
  input  logic          i_fc_dis,
  input  logic          i_issue_off,
  input  logic          i_issue_on,
  input  logic          i_force_on,
  output logic          o_is_on,
  output logic          o_want_off,
  output logic          o_want_on
);

  logic r_is_on;

  // Forced ON wins: the fatal burst itself puts ON on the bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              r_is_on <= 1'b1;
    else if (i_force_on)  r_is_on <= 1'b1;
    else if (i_issue_off) r_is_on <= 1'b0;
    else if (i_issue_on)  r_is_on <= 1'b1;
    else                  r_is_on <= r_is_on;
  end

  always_comb begin
    o_want_off = r_is_on & (i_occ >= i_off_thr) & ~i_fc_dis;
    o_want_on  = ~r_is_on & ((i_occ < i_on_thr) | i_fc_dis);
  end

  assign o_is_on = r_is_on;

endmodule

// File: rtl/jbi_jpack_fc_ctl.sv
// J_PACK flow-control scheduler: priority pick, request spacing, registered send pulses.
// Optional saturating OFF statistics are built when JBI_JPACK_FC_STATS_EN is defined.
module jbi_jpack_fc_ctl
  import jbi_jpack_pkg::*;
#(
  parameter int CW      = 6,
  parameter int MIN_GAP = 2,
  parameter int STAT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  jbi_jpack_fc_ctl_if.slave bus
);

  localparam int GW = (MIN_GAP < 1) ? 1 : $clog2(MIN_GAP + 1);

  logic [GW-1:0] r_gap;
  logic [1:0]    w_want_off, w_want_on, w_is_on, w_issue_off, w_issue_on;
  jpack_fc_e     w_pick;
  logic          r_send_aok_off, r_send_aok_on, r_send_dok_off, r_send_dok_on;

  jbi_jpack_fc_hyst #(.CW(CW)) u_aok (
    .clk(clk), .rst(rst), .i_occ(bus.aok_occ),
    .i_off_thr(bus.csr_aok_off_thr), .i_on_thr(bus.csr_aok_on_thr),
    .i_fc_dis(bus.csr_fc_dis), .i_issue_off(w_issue_off[CH_AOK]),
    .i_issue_on(w_issue_on[CH_AOK]), .i_force_on(1'b0),
    .o_is_on(w_is_on[CH_AOK]), .o_want_off(w_want_off[CH_AOK]), .o_want_on(w_want_on[CH_AOK])
  );

  jbi_jpack_fc_hyst #(.CW(CW)) u_dok (
    .clk(clk), .rst(rst), .i_occ(bus.dok_occ),
    .i_off_thr(bus.csr_dok_off_thr), .i_on_thr(bus.csr_dok_on_thr),
    .i_fc_dis(bus.csr_fc_dis), .i_issue_off(w_issue_off[CH_DOK]),
    .i_issue_on(w_issue_on[CH_DOK]), .i_force_on(bus.dok_fatal_hold),
    .o_is_on(w_is_on[CH_DOK]), .o_want_off(w_want_off[CH_DOK]), .o_want_on(w_want_on[CH_DOK])
  );

  // Nothing is issued while spacing is pending or the fatal burst owns J_PACK.
  always_comb begin
    if ((r_gap == {GW{1'b0}}) && !bus.dok_fatal_hold) w_pick = fc_pick(w_want_off, w_want_on);
    else                                               w_pick = JP_NONE;
  end

  always_comb begin
    w_issue_off = 2'b00;
    w_issue_on  = 2'b00;
    case (w_pick)
      JP_AOK_OFF: w_issue_off[CH_AOK] = 1'b1;
      JP_DOK_OFF: w_issue_off[CH_DOK] = 1'b1;
      JP_AOK_ON:  w_issue_on[CH_AOK]  = 1'b1;
      JP_DOK_ON:  w_issue_on[CH_DOK]  = 1'b1;
      default: begin
        w_issue_off = 2'b00;
        w_issue_on  = 2'b00;
      end
    endcase
  end

  // Gap counter freezes during the fatal hold so spacing resumes where it left off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       r_gap <= {GW{1'b0}};
    else if (bus.dok_fatal_hold)   r_gap <= r_gap;
    else if (w_pick != JP_NONE)    r_gap <= GW'(MIN_GAP);
    else if (r_gap != {GW{1'b0}})  r_gap <= r_gap - GW'(1);
    else                           r_gap <= r_gap;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_send_aok_off <= 1'b0;
      r_send_dok_off <= 1'b0;
      r_send_aok_on  <= 1'b0;
      r_send_dok_on  <= 1'b0;
    end else begin
      r_send_aok_off <= w_issue_off[CH_AOK];
      r_send_dok_off <= w_issue_off[CH_DOK];
      r_send_aok_on  <= w_issue_on[CH_AOK];
      r_send_dok_on  <= w_issue_on[CH_DOK];
    end
  end

  assign bus.send_aok_off = r_send_aok_off;
  assign bus.send_dok_off = r_send_dok_off;
  assign bus.send_aok_on  = r_send_aok_on;
  assign bus.send_dok_on  = r_send_dok_on;
  assign bus.aok_is_on    = w_is_on[CH_AOK];
  assign bus.dok_is_on    = w_is_on[CH_DOK];

`ifdef JBI_JPACK_FC_STATS_EN
  logic [STAT_W-1:0] r_stat_aok_off, r_stat_dok_off;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_aok_off <= {STAT_W{1'b0}};
      r_stat_dok_off <= {STAT_W{1'b0}};
    end else begin
      if (w_issue_off[CH_AOK] && (r_stat_aok_off != {STAT_W{1'b1}}))
        r_stat_aok_off <= r_stat_aok_off + STAT_W'(1);
      else
        r_stat_aok_off <= r_stat_aok_off;
      if (w_issue_off[CH_DOK] && (r_stat_dok_off != {STAT_W{1'b1}}))
        r_stat_dok_off <= r_stat_dok_off + STAT_W'(1);
      else
        r_stat_dok_off <= r_stat_dok_off;
    end
  end

  assign bus.stat_aok_off_cnt = r_stat_aok_off;
  assign bus.stat_dok_off_cnt = r_stat_dok_off;
`else
  assign bus.stat_aok_off_cnt = {STAT_W{1'b0}};
  assign bus.stat_dok_off_cnt = {STAT_W{1'b0}};
`endif

endmodule

// File: tb/tb_jbi_jpack_fc_ctl.sv
// Scoreboard bench for jbi_jpack_fc_ctl: a cycle-level reference model queues the
// expected outputs at each edge; a monitor compares them on the falling edge.
module tb_jbi_jpack_fc_ctl;

  localparam int CW      = 6;
  localparam int MIN_GAP = 2;
  localparam int STAT_W  = 2;

  typedef struct packed {
    logic [3:0]        send;   // {dok_on, aok_on, dok_off, aok_off}
    logic              aok_on;
    logic              dok_on;
    logic [STAT_W-1:0] st_aok;
    logic [STAT_W-1:0] st_dok;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  jbi_jpack_fc_ctl_if #(.CW(CW), .STAT_W(STAT_W)) bus ();

  jbi_jpack_fc_ctl #(.CW(CW), .MIN_GAP(MIN_GAP), .STAT_W(STAT_W)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  int m_gap;
  bit m_on[2];
  int m_stat[2];

  function automatic exp_t model_out(input logic [3:0] send);
    exp_t e;
    e.send   = send;
    e.aok_on = m_on[0];
    e.dok_on = m_on[1];
    e.st_aok = STAT_W'(m_stat[0]);
    e.st_dok = STAT_W'(m_stat[1]);
    return e;
  endfunction

  always @(posedge clk) begin
    logic [3:0] send;
    int occ[2], offt[2], ont[2];
    bit want[4];
    send = 4'b0000;
    if (rst) begin
      m_gap = 0; m_on[0] = 1'b1; m_on[1] = 1'b1; m_stat[0] = 0; m_stat[1] = 0;
    end else begin
      occ[0] = int'(bus.aok_occ);  occ[1] = int'(bus.dok_occ);
      offt[0] = int'(bus.csr_aok_off_thr); offt[1] = int'(bus.csr_dok_off_thr);
      ont[0] = int'(bus.csr_aok_on_thr);   ont[1] = int'(bus.csr_dok_on_thr);
      // candidates in priority order: aok_off, dok_off, aok_on, dok_on
      for (int c = 0; c < 2; c++) begin
        want[c]   = m_on[c] && (occ[c] >= offt[c]) && !bus.csr_fc_dis;
        want[c+2] = !m_on[c] && ((occ[c] < ont[c]) || bus.csr_fc_dis);
      end
      if (bus.dok_fatal_hold) begin
        m_on[1] = 1'b1;
      end else if (m_gap > 0) begin
        m_gap = m_gap - 1;
      end else begin
        for (int k = 0; k < 4; k++) begin
          if (want[k] && send == 4'b0000) begin
            send[k] = 1'b1;
            m_on[k % 2] = (k >= 2);
            m_gap = MIN_GAP;
`ifdef JBI_JPACK_FC_STATS_EN
            if (k < 2 && m_stat[k] < (1 << STAT_W) - 1) m_stat[k] = m_stat[k] + 1;
`endif
          end
        end
      end
    end
    q.push_back(model_out(send));
  end

  // Monitor
  always @(negedge clk) begin
    exp_t e, a;
    if (q.size() > 0) begin
      e = q.pop_front();
      a.send   = {bus.send_dok_on, bus.send_aok_on, bus.send_dok_off, bus.send_aok_off};
      a.aok_on = bus.aok_is_on;
      a.dok_on = bus.dok_is_on;
      a.st_aok = bus.stat_aok_off_cnt;
      a.st_dok = bus.stat_dok_off_cnt;
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL cycle_outputs t=%0t got send=%b aok_on=%b dok_on=%b st=%0d/%0d expected send=%b aok_on=%b dok_on=%b st=%0d/%0d",
                 $time, a.send, a.aok_on, a.dok_on, a.st_aok, a.st_dok,
                 e.send, e.aok_on, e.dok_on, e.st_aok, e.st_dok);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_thr(input logic [CW-1:0] off_t, input logic [CW-1:0] on_t);
    bus.csr_aok_off_thr = off_t; bus.csr_aok_on_thr = on_t;
    bus.csr_dok_off_thr = off_t; bus.csr_dok_on_thr = on_t;
  endtask

  initial begin
    bus.aok_occ = 6'd0; bus.dok_occ = 6'd0;
    set_thr(6'd40, 6'd32);
    bus.csr_fc_dis = 1'b0; bus.dok_fatal_hold = 1'b0;
    step(3);
    rst = 1'b0;
    step(2);
    // single AOK OFF, no repeat while held at threshold
    bus.aok_occ = 6'd40; step(5);
    // hysteresis band then ON
    bus.aok_occ = 6'd35; step(4);
    bus.aok_occ = 6'd31; step(5);
    // both cross OFF together: gap spacing
    bus.aok_occ = 6'd45; bus.dok_occ = 6'd45; step(8);
    // fatal hold while DOK is OFF and still above threshold
    bus.dok_fatal_hold = 1'b1; step(4);
    bus.dok_fatal_hold = 1'b0; step(6);
    // flow control disabled with full buffers
    bus.aok_occ = 6'd63; bus.dok_occ = 6'd63; bus.csr_fc_dis = 1'b1; step(10);
    bus.csr_fc_dis = 1'b0; step(8);
    bus.aok_occ = 6'd0; bus.dok_occ = 6'd0; step(8);
    // repeated AOK OFF/ON to exercise stat saturation
    for (int i = 0; i < 5; i++) begin
      bus.aok_occ = 6'd50; step(4);
      bus.aok_occ = 6'd10; step(4);
    end
    // asynchronous reset mid-gap with a send pulse in flight
    bus.aok_occ = 6'd50; step(1);
    #2 rst = 1'b1;
    q.delete();
    #1;
    checks++;
    if ({bus.send_aok_off, bus.send_aok_on, bus.send_dok_off, bus.send_dok_on} !== 4'b0000 ||
        bus.aok_is_on !== 1'b1 || bus.dok_is_on !== 1'b1 ||
        bus.stat_aok_off_cnt !== '0 || bus.stat_dok_off_cnt !== '0) begin
      errors++;
      $display("FAIL async_reset got sends=%b%b%b%b is_on=%b%b st=%0d/%0d expected sends=0000 is_on=11 st=0/0",
               bus.send_aok_off, bus.send_aok_on, bus.send_dok_off, bus.send_dok_on,
               bus.aok_is_on, bus.dok_is_on, bus.stat_aok_off_cnt, bus.stat_dok_off_cnt);
    end
    step(2);
    rst = 1'b0;
    step(2);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) < 3) bus.aok_occ = CW'($urandom_range(0, 63));
      if ($urandom_range(0, 9) < 3) bus.dok_occ = CW'($urandom_range(0, 63));
      if ($urandom_range(0, 99) < 2) begin
        bus.csr_aok_off_thr = CW'($urandom_range(0, 63)); bus.csr_aok_on_thr = CW'($urandom_range(0, 63));
        bus.csr_dok_off_thr = CW'($urandom_range(0, 63)); bus.csr_dok_on_thr = CW'($urandom_range(0, 63));
      end
      if ($urandom_range(0, 99) < 3) bus.csr_fc_dis = ~bus.csr_fc_dis;
      if (bus.dok_fatal_hold) begin
        if ($urandom_range(0, 9) < 3) bus.dok_fatal_hold = 1'b0;
      end else begin
        if ($urandom_range(0, 99) < 5) bus.dok_fatal_hold = 1'b1;
      end
      step(1);
    end
    step(2);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
